// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode enumeration, widths and flag bundle shared by the ALU pipeline
package alu_pipe_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD     = 3'b000,
      OP_SUB     = 3'b001,
      OP_AND     = 3'b010,
      OP_CMP     = 3'b011,
      OP_OR      = 3'b100,
      OP_XOR     = 3'b101,
      OP_ACC     = 3'b110,
      OP_ACC_CLR = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic carry;
      logic sign;
      logic gt;
      logic eq;
      logic lt;
      logic zero;
      logic err;
   } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - request/result handshake bundle of the ALU pipeline
interface alu_pipe_if
   import alu_pipe_pkg::*;
#(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [OP_W-1:0]  op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             sign;
   logic             gt;
   logic             eq;
   logic             lt;
   logic             zero;
   logic             err;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, sign, gt, eq, lt, zero, err
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, sign, gt, eq, lt, zero, err
   );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational result/flag compute; ACC ops only with ALU_PIPE_ACC_EN
module alu_core
   import alu_pipe_pkg::*;
#(parameter int WIDTH = 8)
(
`ifdef ALU_PIPE_ACC_EN
   input  logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] acc_next,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   output logic [WIDTH-1:0] result,
   output alu_flags_t       flags
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
`ifdef ALU_PIPE_ACC_EN
   logic [WIDTH:0] acc_sum;
`endif

   // Decode the opcode into a result and flags; compare flags hold for every op
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      result = '0;
      flags  = '0;
`ifdef ALU_PIPE_ACC_EN
      acc_sum  = {1'b0, acc} + {1'b0, a};
      acc_next = acc;
`endif
      flags.gt = (a > b);
      flags.eq = (a == b);
      flags.lt = (a < b);
      case (op)
         OP_ADD: begin
            result      = sum[WIDTH-1:0];
            flags.carry = sum[WIDTH];
         end
         OP_SUB: begin
            result     = diff[WIDTH-1:0];
            flags.sign = (a < b);
         end
         OP_AND: result = a & b;
         OP_CMP: result = '0;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
`ifdef ALU_PIPE_ACC_EN
         OP_ACC: begin
            acc_next    = acc_sum[WIDTH-1:0];
            result      = acc_sum[WIDTH-1:0];
            flags.carry = acc_sum[WIDTH];
         end
         OP_ACC_CLR: begin
            acc_next = '0;
            result   = '0;
         end
`else
         OP_ACC:     flags.err = 1'b1;
         OP_ACC_CLR: flags.err = 1'b1;
`endif
      endcase
      flags.zero = (result == '0);
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline with valid/ready handshake; accumulator under ALU_PIPE_ACC_EN
module alu_pipe
   import alu_pipe_pkg::*;
#(parameter int WIDTH = 8)
(
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);

   logic             s1_full;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   alu_op_e          s1_op;
   logic             s2_full;
   logic [WIDTH-1:0] s2_result;
   alu_flags_t       s2_flags;
   logic [WIDTH-1:0] core_result;
   alu_flags_t       core_flags;
   logic             s2_free;
   logic             s1_adv;
   logic             in_fire;

   // S2 can take a new item when empty or when its current item leaves this edge
   assign s2_free      = !s2_full || bus.out_ready;
   assign s1_adv       = s1_full && s2_free;
   assign bus.in_ready = !rst && (!s1_full || s2_free);
   assign in_fire      = bus.in_valid && bus.in_ready;

`ifdef ALU_PIPE_ACC_EN
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .acc      (acc),
      .acc_next (acc_next),
      .a        (s1_a),
      .b        (s1_b),
      .op       (s1_op),
      .result   (core_result),
      .flags    (core_flags)
   );

   // Accumulator commits as its op moves S1->S2, so a following ACC in S1 sees it
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (s1_adv) begin
         acc <= acc_next;
      end
   end
`else
   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .result (core_result),
      .flags  (core_flags)
   );
`endif

   // S1 operand register: load on accepted request, empty when it moves on
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_full <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_op   <= OP_ADD;
      end else if (in_fire) begin
         s1_full <= 1'b1;
         s1_a    <= bus.a;
         s1_b    <= bus.b;
         s1_op   <= alu_op_e'(bus.op);
      end else if (s1_adv) begin
         s1_full <= 1'b0;
      end
   end

   // S2 result register: held unchanged while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_full   <= 1'b0;
         s2_result <= '0;
         s2_flags  <= '0;
      end else if (s1_adv) begin
         s2_full   <= 1'b1;
         s2_result <= core_result;
         s2_flags  <= core_flags;
      end else if (bus.out_ready) begin
         s2_full <= 1'b0;
      end
   end

   assign bus.out_valid = s2_full;
   assign bus.result    = s2_result;
   assign bus.carry     = s2_flags.carry;
   assign bus.sign      = s2_flags.sign;
   assign bus.gt        = s2_flags.gt;
   assign bus.eq        = s2_flags.eq;
   assign bus.lt        = s2_flags.lt;
   assign bus.zero      = s2_flags.zero;
   assign bus.err       = s2_flags.err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized scoreboard bench for alu_pipe at WIDTH=4 (either ALU_PIPE_ACC_EN build)
module tb_alu_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   acc_m = 0;
   bit   rand_ready = 1'b0;

   typedef struct {
      logic [10:0] exp;
      int          cyc;
      bit          clean;
   } item_t;
   item_t q[$];

   alu_pipe_if #(.WIDTH(4)) bus();

   alu_pipe #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Expected {result[3:0], carry, sign, gt, eq, lt, zero, err}, from the arithmetic rules
   function automatic logic [10:0] model(input int a, input int b, input int op);
      int r = 0;
      bit c = 0, s = 0, e = 0;
      logic [3:0] rv;
      case (op)
         0: begin r = a + b; c = (r > 15); r = r % 16; end
         1: begin r = (a - b + 16) % 16; s = (a < b); end
         2: r = a & b;
         3: r = 0;
         4: r = a | b;
         5: r = a ^ b;
`ifdef ALU_PIPE_ACC_EN
         6: begin r = acc_m + a; c = (r > 15); r = r % 16; acc_m = r; end
         7: begin r = 0; acc_m = 0; end
`else
         6: begin r = 0; e = 1; end
         7: begin r = 0; e = 1; end
`endif
         default: r = 0;
      endcase
      rv = r[3:0];
      return {rv, c, s, a > b, a == b, a < b, rv == 4'd0, e};
   endfunction

   function automatic logic [10:0] dut_out();
      return {bus.result, bus.carry, bus.sign, bus.gt, bus.eq, bus.lt, bus.zero, bus.err};
   endfunction

   // Monitor: scoreboard at negedge, where the state reflects what the next edge will do
   initial begin : monitor
      bit          stall_prev = 0;
      logic [10:0] held = '0;
      item_t       it;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            q.delete();
            acc_m = 0;
            stall_prev = 0;
         end else begin
            if (stall_prev) begin
               check("stall_valid", 32'(bus.out_valid), 32'd1);
               check("stall_hold", 32'(dut_out()), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (q.size() == 0) begin
                  check("no_extra_output", 32'd1, 32'd0);
               end else begin
                  it = q.pop_front();
                  check("result", 32'(bus.result), 32'(it.exp[10:7]));
                  check("flags", 32'(dut_out() & 11'h07f), 32'(it.exp & 11'h07f));
                  if (it.clean) check("latency", 32'(cyc - it.cyc), 32'd2);
               end
            end
            if (!bus.out_ready) foreach (q[i]) q[i].clean = 0;
            if (bus.in_valid && bus.in_ready) begin
               it.exp   = model(int'(bus.a), int'(bus.b), int'(bus.op));
               it.cyc   = cyc;
               it.clean = bus.out_ready;
               q.push_back(it);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held = dut_out();
         end
      end
   end

   // Random downstream backpressure when enabled
   always @(posedge clk) begin
      if (rand_ready) begin
         #1 bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input int av, input int bv, input int opv);
      bit done = 0;
      bus.in_valid = 1'b1;
      bus.a  = av[3:0];
      bus.b  = bv[3:0];
      bus.op = opv[2:0];
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !bus.out_valid) done = 1;
      end
      check("drained", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("post_rst_outputs", 32'(dut_out()), 32'd0);
      @(posedge clk);
      #1;

      // Known vectors, issued back to back
      send(4, 10, 0);
      send(15, 13, 0);
      send(13, 10, 1);
      send(2, 13, 1);
      send(15, 15, 3);
      send(10, 5, 2);
      send(0, 0, 7);
      send(7, 3, 6);
      send(12, 9, 6);
      send(9, 6, 4);
      send(9, 6, 5);
      drain();

      // Backpressure: two items fill S1/S2, a third waits, then release
      bus.out_ready = 1'b0;
      send(1, 2, 0);
      send(8, 3, 1);
      bus.in_valid = 1'b1;
      bus.a = 4'd5; bus.b = 4'd5; bus.op = 3'd3;
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      send(5, 5, 3);
      send(6, 12, 2);
      drain();

      // Reset with two items in flight
      bus.out_ready = 1'b0;
      send(3, 4, 0);
      send(5, 6, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("flush_out_valid", 32'(bus.out_valid), 32'd0);
      check("flush_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("flush_after_in_ready", 32'(bus.in_ready), 32'd1);
      check("flush_after_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      send(0, 0, 6);
      send(11, 0, 6);
      drain();

      // Random traffic with random backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2 bus.out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
